// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state encoding and small helpers for the execute unit.
// Pure declarations: no latency.
// No flow control.
package alu_pkg;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_XOR   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SRL   = 5'd7;
    localparam logic [4:0] OP_SRA   = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;
    localparam logic [4:0] OP_MTHI  = 5'd17;
    localparam logic [4:0] OP_MTLO  = 5'd18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    function automatic logic is_mdu_op(input logic [4:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_signed_mdu(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes.
// Latency: WIDTH iterations plus one FIX cycle; done is high during FIX.
// Accepts start only while idle; flush abandons the operation with no done.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);
    localparam int CW = cnt_bits(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, q, opd;
    logic             neg_q, neg_r, is_div, div0;
    logic             sgn;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   add_sum, shifted, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = is_mul_op(op) ? MUL : DIV;
            MUL, DIV: begin
                if (flush)          state_nxt = IDLE;
                else if (cnt == '0) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == FIX) && !flush;
    end

    always_comb begin
        sgn     = is_signed_mdu(op);
        mag_a   = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b   = (sgn && b[WIDTH-1]) ? -b : b;
        add_sum = {1'b0, acc} + (q[0] ? {1'b0, opd} : '0);
        shifted = {acc, q[WIDTH-1]};
        diff    = shifted - {1'b0, opd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            q      <= '0;
            opd    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            div0   <= 1'b0;
        end else if (start) begin
            cnt    <= CW'(WIDTH - 1);
            acc    <= '0;
            q      <= mag_a;
            opd    <= mag_b;
            neg_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn && a[WIDTH-1];
            is_div <= !is_mul_op(op);
            div0   <= (b == '0);
        end else if (state == MUL) begin
            // {acc,q} holds the partial product; multiplier bits retire from q[0]
            {acc, q} <= {add_sum, q[WIDTH-1:1]};
            cnt      <= cnt - 1'b1;
        end else if (state == DIV) begin
            if (!diff[WIDTH]) begin
                acc <= diff[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], 1'b1};
            end else begin
                acc <= shifted[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
        end
    end

    // MIN / -1 needs no special case: magnitude quotient 2^(W-1) negates to itself.
    always_comb begin
        prod = neg_q ? -{acc, q} : {acc, q};
        quo  = neg_q ? -q : q;
        rem  = neg_r ? -acc : acc;
        if (is_div) begin
            hi_q = rem;
            lo_q = div0 ? '1 : quo;
        end else begin
            hi_q = prod[2*WIDTH-1:WIDTH];
            lo_q = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with HI/LO registers and iterative multiply/divide.
// Latency: 1 edge for ALU/move ops, WIDTH+1 edges for mult/div.
// in_ready drops while mult/div is in flight; no output backpressure.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic             accept, mdu_start, mdu_done;
    logic [WIDTH-1:0] alu_res, hi_q, lo_q;

    assign in_ready  = !busy;
    assign accept    = in_valid && in_ready && !flush;
    assign mdu_start = accept && is_mdu_op(op);

    mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mdu_start),
        .flush (flush),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (mdu_done),
        .hi_q  (hi_q),
        .lo_q  (lo_q)
    );

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = b << a[SHAMT_W-1:0];
            OP_SRL:  alu_res = b >> a[SHAMT_W-1:0];
            OP_SRA:  alu_res = $signed(b) >>> a[SHAMT_W-1:0];
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            OP_MTHI: alu_res = a;
            OP_MTLO: alu_res = a;
            default: alu_res = '0;
        endcase
    end

    // accept and mdu_done are exclusive: accept needs the engine idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi        <= '0;
            lo        <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_mdu_op(op)) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
            end else if (mdu_done) begin
                hi        <= hi_q;
                lo        <= lo_q;
                result    <= lo_q;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised execute-stage unit for the MIPS pipeline, successor to the single-cycle ALU. It keeps the eleven single-cycle ALU operations with the same encodings, now at generic width and with a registered result. It adds an iterative multiply/divide engine with architectural HI/LO registers, a valid/ready input handshake for stalling the pipe, and a flush input for squashing in-flight work.

## Interface
- WIDTH, 32: datapath width; must be ≥ 4 and a power of two.
- SHAMT_W, $clog2(WIDTH): shift-amount bits taken from a.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept; equals !busy.
- op  in  5  operation code (see Operation).
- a  in  WIDTH  operand A (rs, or shamt for shifts).
- b  in  WIDTH  operand B.
- flush  in  1  squash in-flight or presented op.
- out_valid  out  1  one-cycle pulse, result valid.
- result  out  WIDTH  registered result.
- busy  out  1  mult/div in progress.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- Opcodes 0–10: ADD, SUB, AND, OR, XOR, NOR, SLL (b<<a[SHAMT_W-1:0]), SRL, SRA, SLT (signed), SLTU. All wrap modulo 2^WIDTH; there is no overflow trap.
- 11 MULT, 12 MULTU: 2·WIDTH-bit product; HI=upper, LO=lower.
- 13 DIV, 14 DIVU: LO=quotient, HI=remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: LO=all ones, HI=a (both signed and unsigned).
- Signed overflow (most-negative / -1): LO=most-negative, HI=0.
- 15 MFHI, 16 MFLO: result=hi/lo.
- 17 MTHI, 18 MTLO: hi/lo←a; result=a.
- Codes 19–31: result=0; out_valid still pulses.
- For mult/div, the completion pulse carries result=new LO.
- An op is accepted on a rising edge with in_valid && in_ready && !flush.
- FSM states:
  - IDLE→MUL or DIV on accept of 11–14. Operands are latched as magnitudes for signed ops; the sign of the result is recorded.
  - MUL/DIV: radix-2 shift-add or restoring shift-subtract, one bit per cycle, WIDTH iterations, counter WIDTH-1..0.
  - When the counter reaches 0: →FIX.
  - FIX: apply sign correction and the special cases, write HI/LO, pulse out_valid, →IDLE.
- flush:
  - In MUL/DIV/FIX: →IDLE on the next edge. HI/LO unchanged, no out_valid.
  - flush together with in_valid: the op is dropped.
  - flush in IDLE with nothing presented: no effect.
- Reset: state IDLE; hi, lo, result=0; out_valid=0; busy=0; in_ready=1 once rst_n is high. Reset mid-operation discards it.

## Timing
- Single-cycle ops (0–10, 15–18) accepted at edge k: result and out_valid are valid in the cycle after edge k. Back-to-back accepts give one result per cycle.
- MTHI/MTLO: hi/lo update at edge k. An MFHI accepted at k+1 returns the new value.
- Mult/div accepted at edge k:
  - busy=1 and in_ready=0 after edges k … k+WIDTH.
  - FIX occupies the cycle after edge k+WIDTH.
  - HI/LO, result and out_valid update at edge k+WIDTH+1; busy=0 in the same cycle.
  - Latency is WIDTH+1 edges (33 for WIDTH=32).
  - A new op may be accepted at edge k+WIDTH+1. The next op, including MFHI, is issued no earlier than that edge, so it sees the updated HI/LO.
- There is no output backpressure. out_valid is never high for two consecutive cycles from the same op.
- in_ready is combinational from state only, with no path from in_valid.

## Structure
- Package alu_pkg holds:
  - the op-code localparams (OP_ADD … OP_MTLO, 5-bit);
  - the FSM state enum (IDLE, MUL, DIV, FIX);
  - the width helper functions.
- Sub-module mdu_iter(WIDTH) contains the iterative engine:
  - accumulator, operand shift registers, iteration counter, sign flags;
  - start/flush inputs; done, hi_q and lo_q outputs.
- alu_mdu top-level contains the single-cycle datapath, HI/LO registers, handshake and output register.

## Test plan
- ADD 0x7FFFFFFF+1 → result 0x80000000 one cycle later; SRA b=0x80000000, a=4 → 0xF8000000; SLT a=-1, b=1 → 1; SLTU a=-1, b=1 → 0.
- MULT a=-3, b=5 → out_valid exactly 33 edges after accept; HI=0xFFFFFFFF, LO=0xFFFFFFF1; in_ready low throughout. MULTU 0xFFFFFFFF² → HI=0xFFFFFFFE, LO=1.
- DIV a=7, b=-2 → LO=0xFFFFFFFD, HI=1; DIV a=-7, b=2 → LO=-3, HI=-1; DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIVU a=5, b=0 → LO=0xFFFFFFFF, HI=5; then MFHI → 5 one cycle after accept.
- flush at iteration 10 of a DIV → no out_valid, HI/LO keep their prior values, in_ready=1 next cycle. flush together with in_valid for MTHI → HI unchanged.
- rst_n low mid-MULT → outputs 0 and in_ready=1 asynchronously. Opcode 25 → result 0, out_valid pulses.
